// File: rtl/mesh_pkg.sv
// Shared definitions for the sorting mesh: sequencer state encoding and
// elaboration-time sizing helpers used by the sequencer, mesh and PEs.
package mesh_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ROW   = 3'd1,
    S_COL   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  // Bits needed to hold values 0..value-1; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Shearsort: LOG_SQRT_N+1 row phases interleaved with LOG_SQRT_N column phases.
  function automatic int num_phases(input int log_sqrt_n);
    return 2 * log_sqrt_n + 1;
  endfunction

endpackage

// File: rtl/mesh_seq_step_counter.sv
// Step counter for one odd-even transposition phase: counts 0..MAX-1 and wraps,
// flagging the final step so the sequencer can advance to the next phase.
module mesh_seq_step_counter
  import mesh_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = (clog2(MAX) < 1) ? 1 : clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] count_q;

  assign last  = (count_q == W'(MAX - 1));
  assign count = count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= last ? '0 : count_q + W'(1);
    end
  end

endmodule

// File: rtl/mesh_sort_sequencer.sv
// Global shearsort phase controller: row/column odd-even phases, then one write commit.
// Optional freeze input `hold` is enabled by defining MESH_SORT_SEQ_HOLD_EN.
module mesh_sort_sequencer
  import mesh_pkg::*;
#(
  parameter int N           = 4,
  parameter int SQRT_N      = 2,
  parameter int SORT_CYCLES = 4,
  parameter int LOG_SQRT_N  = 1,
  parameter int NUM_PHASES  = num_phases(LOG_SQRT_N),
  parameter int PIDX_W      = clog2(NUM_PHASES),
  parameter int STEP_W      = (clog2(SORT_CYCLES) < 1) ? 1 : clog2(SORT_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef MESH_SORT_SEQ_HOLD_EN
  input  logic              hold,
`endif
  output logic              busy,
  output logic              phase_row,
  output logic              step_odd,
  output logic              cmp_en,
  output logic              write_en,
  output logic [PIDX_W-1:0] phase_idx,
  output logic              done
);

  if (N != SQRT_N * SQRT_N || (1 << LOG_SQRT_N) != SQRT_N || SORT_CYCLES < SQRT_N)
  begin : g_param_check
    $error("mesh_sort_sequencer: inconsistent mesh parameters");
  end

  seq_state_e        state_q, state_d;
  logic [PIDX_W-1:0] phase_idx_q, phase_idx_d;
  logic [STEP_W-1:0] step_q;
  logic              step_last;
  logic              hold_eff;
  logic              running_q, running_d;
  logic              advance;

  logic busy_q, busy_d;
  logic phase_row_q, phase_row_d;
  logic cmp_en_q, cmp_en_d;
  logic write_en_q, write_en_d;
  logic done_q, done_d;

`ifdef MESH_SORT_SEQ_HOLD_EN
  assign hold_eff = hold && (state_q inside {S_ROW, S_COL, S_WRITE});
`else
  assign hold_eff = 1'b0;
`endif

  assign running_q = (state_q inside {S_ROW, S_COL});
  assign running_d = (state_d inside {S_ROW, S_COL});
  assign advance   = running_q && !hold_eff;

  // Cleared from the next state so the count always matches the registered phase outputs.
  mesh_seq_step_counter #(
    .MAX (SORT_CYCLES),
    .W   (STEP_W)
  ) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (!running_d),
    .en    (advance),
    .count (step_q),
    .last  (step_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_idx_q <= '0;
      busy_q      <= 1'b0;
      phase_row_q <= 1'b0;
      cmp_en_q    <= 1'b0;
      write_en_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_idx_q <= phase_idx_d;
      busy_q      <= busy_d;
      phase_row_q <= phase_row_d;
      cmp_en_q    <= cmp_en_d;
      write_en_q  <= write_en_d;
      done_q      <= done_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    phase_idx_d = phase_idx_q;
    unique case (state_q)
      S_IDLE: begin
        phase_idx_d = '0;
        if (start) state_d = S_ROW;
      end
      S_ROW, S_COL: begin
        if (advance && step_last) begin
          if (phase_idx_q == PIDX_W'(NUM_PHASES - 1)) begin
            state_d     = S_WRITE;
            phase_idx_d = '0;
          end else begin
            state_d     = (state_q == S_ROW) ? S_COL : S_ROW;
            phase_idx_d = phase_idx_q + PIDX_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (!hold_eff) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        phase_idx_d = '0;
      end
      default: begin
        state_d     = S_IDLE;
        phase_idx_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, aligned with state_q.
  always_comb begin
    busy_d      = (state_d inside {S_ROW, S_COL, S_WRITE});
    phase_row_d = (state_d == S_ROW);
    cmp_en_d    = running_d && !hold_eff;
    write_en_d  = (state_d == S_WRITE) && !hold_eff;
    done_d      = (state_d == S_DONE);
  end

  assign busy      = busy_q;
  assign phase_row = phase_row_q;
  assign step_odd  = step_q[0];
  assign cmp_en    = cmp_en_q;
  assign write_en  = write_en_q;
  assign phase_idx = phase_idx_q;
  assign done      = done_q;

endmodule
